// File: rtl/pwm_duty_meter.sv
// PWM duty-cycle meter: measures rise-to-rise period and high time, divides to whole percent and
// drives three 7-segment digits. Define PWM_METER_ROUND_EN for round-to-nearest instead of floor.
module pwm_duty_meter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pwm_in_i,
  output logic [6:0] duty_o,
  output logic       duty_valid_o,
  output logic       overrun_o,
  output logic [6:0] hex0_o,
  output logic [6:0] hex1_o,
  output logic [6:0] hex2_o
);

  localparam int unsigned NumW  = CNT_W + 7;
  localparam int unsigned StepW = $clog2(NumW);
  localparam logic [6:0]  Blank = 7'b1111111;

  typedef enum logic [1:0] {StIdle, StMeasure, StDivide} state_e;

  state_e             state_q;
  logic [2:0]         sync_q;
  logic               rise_q;
  logic [CNT_W-1:0]   per_q, hi_q;
  logic [CNT_W-1:0]   per_inc, hi_inc;
  logic [NumW-1:0]    div_num_q;
  logic [CNT_W-1:0]   div_rem_q, div_den_q;
  logic [StepW-1:0]   div_cnt_q;
  logic [6:0]         duty_q;
  logic               duty_valid_q, overrun_q;
  logic [6:0]         hex0_q, hex1_q, hex2_q;

  // sync_q[1:0] is the two-flop synchronizer; sync_q[2] is aligned with rise_q
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], pwm_in_i};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign per_inc = (per_q == '1) ? per_q : per_q + 1'b1;
  assign hi_inc  = (hi_q == '1 || !sync_q[2]) ? hi_q : hi_q + 1'b1;

  logic [NumW-1:0]  num_init;
  logic [CNT_W:0]   rem_shift;
  logic [CNT_W-1:0] rem_diff, rem_next;
  logic             q_bit;
  logic [NumW-1:0]  quo_next;
  logic [6:0]       duty_div;

  always_comb begin
`ifdef PWM_METER_ROUND_EN
    num_init = NumW'(hi_q) * NumW'(100) + NumW'(per_q >> 1);
`else
    num_init = NumW'(hi_q) * NumW'(100);
`endif
    rem_shift = {div_rem_q, div_num_q[NumW-1]};
    q_bit     = rem_shift >= {1'b0, div_den_q};
    // True difference is below the divisor, so CNT_W-bit wraparound is exact
    rem_diff  = rem_shift[CNT_W-1:0] - div_den_q;
    rem_next  = q_bit ? rem_diff : rem_shift[CNT_W-1:0];
    quo_next  = {div_num_q[NumW-2:0], q_bit};
    duty_div  = (quo_next > NumW'(100)) ? 7'd100 : quo_next[6:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      per_q        <= '0;
      hi_q         <= '0;
      div_num_q    <= '0;
      div_rem_q    <= '0;
      div_den_q    <= '0;
      div_cnt_q    <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      duty_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          per_q <= '0;
          hi_q  <= '0;
          if (rise_q) begin
            per_q   <= CNT_W'(1);
            hi_q    <= CNT_W'(1);
            state_q <= StMeasure;
          end
        end
        StMeasure: begin
          if (rise_q) begin
            div_num_q <= num_init;
            div_rem_q <= '0;
            div_den_q <= per_q;
            div_cnt_q <= '0;
            per_q     <= CNT_W'(1);
            hi_q      <= CNT_W'(1);
            state_q   <= StDivide;
          end else if (per_q >= CNT_W'(TIMEOUT)) begin
            duty_q       <= sync_q[2] ? 7'd100 : 7'd0;
            duty_valid_q <= 1'b1;
            per_q        <= '0;
            hi_q         <= '0;
            state_q      <= StIdle;
          end else begin
            per_q <= per_inc;
            hi_q  <= hi_inc;
          end
        end
        StDivide: begin
          div_num_q <= quo_next;
          div_rem_q <= rem_next;
          div_cnt_q <= div_cnt_q + 1'b1;
          // A rise here ends a period we cannot divide; keep measuring the next one
          if (rise_q) begin
            overrun_q <= 1'b1;
            per_q     <= CNT_W'(1);
            hi_q      <= CNT_W'(1);
          end else begin
            per_q <= per_inc;
            hi_q  <= hi_inc;
          end
          if (div_cnt_q == StepW'(NumW - 1)) begin
            duty_q       <= duty_div;
            duty_valid_q <= 1'b1;
            state_q      <= StMeasure;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    unique case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = Blank;
    endcase
  endfunction

  logic [3:0] ones, tens;
  always_comb begin
    ones = 4'(duty_q % 7'd10);
    tens = 4'((duty_q / 7'd10) % 7'd10);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hex0_q <= 7'b1000000;
      hex1_q <= Blank;
      hex2_q <= Blank;
    end else begin
      hex0_q <= seg(ones);
      hex1_q <= (duty_q >= 7'd10) ? seg(tens) : Blank;
      hex2_q <= (duty_q == 7'd100) ? seg(4'd1) : Blank;
    end
  end

  assign duty_o       = duty_q;
  assign duty_valid_o = duty_valid_q;
  assign overrun_o    = overrun_q;
  assign hex0_o       = hex0_q;
  assign hex1_o       = hex1_q;
  assign hex2_o       = hex2_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: directed PWM patterns push expected duty values, a
// monitor pops them on each duty_valid and checks duty and the following HEX update.
module tb_pwm_duty_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm = 1'b0;
  logic [6:0] duty, hex0, hex1, hex2;
  logic       duty_valid, overrun;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int free_exp = -1;
  logic hex_pend = 1'b0;
  int   hex_val  = 0;

  localparam logic [6:0] Blank = 7'b1111111;

  pwm_duty_meter #(.CNT_W(16), .TIMEOUT(1000)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pwm_in_i    (pwm),
    .duty_o      (duty),
    .duty_valid_o(duty_valid),
    .overrun_o   (overrun),
    .hex0_o      (hex0),
    .hex1_o      (hex1),
    .hex2_o      (hex2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0:       enc = 7'b1000000;
      1:       enc = 7'b1111001;
      2:       enc = 7'b0100100;
      3:       enc = 7'b0110000;
      4:       enc = 7'b0011001;
      5:       enc = 7'b0010010;
      6:       enc = 7'b0000010;
      7:       enc = 7'b1111000;
      8:       enc = 7'b0000000;
      9:       enc = 7'b0010000;
      default: enc = Blank;
    endcase
  endfunction

  // Monitor: HEX is checked on the cycle after the duty_valid it belongs to
  always @(negedge clk) begin : monitor
    int e;
    if (rst) begin
      hex_pend <= 1'b0;
    end else begin
      if (hex_pend) begin
        check("hex0", int'(hex0), int'(enc(hex_val % 10)));
        check("hex1", int'(hex1), int'((hex_val >= 10) ? enc((hex_val / 10) % 10) : Blank));
        check("hex2", int'(hex2), int'((hex_val == 100) ? enc(1) : Blank));
        hex_pend <= 1'b0;
      end
      if (duty_valid) begin
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else if (free_exp >= 0) e = free_exp;
        else check("unexpected_valid", int'(duty), -1);
        if (e >= 0) begin
          check("duty", int'(duty), e);
          hex_pend <= 1'b1;
          hex_val  <= e;
        end
      end
    end
  end

  task automatic run(input int per, input int hi, input int exp);
    if (exp >= 0) exp_q.push_back(exp);
    pwm = 1'b1;
    repeat (hi) @(negedge clk);
    pwm = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_duty"}, int'(duty), 0);
    check({tag, "_valid"}, int'(duty_valid), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_hex0"}, int'(hex0), int'(7'b1000000));
    check({tag, "_hex1"}, int'(hex1), int'(Blank));
    check({tag, "_hex2"}, int'(hex2), int'(Blank));
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int waited;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    repeat (50) @(negedge clk);

    repeat (3) run(100, 50, 50);
    repeat (2) run(100, 60, 60);
    repeat (2) run(100, 70, 70);
    repeat (2) run(100, 60, 60);
    run(300, 100, 33);
`ifdef PWM_METER_ROUND_EN
    run(300, 2, 1);
`else
    run(300, 2, 0);
`endif

    // Static high: the rise closes the previous period, then the line times out
    exp_q.push_back(100);
    pwm = 1'b1;
    repeat (1100) @(negedge clk);
    check("drain_high", exp_q.size(), 0);

    pwm = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back(0);
    pwm = 1'b1;
    repeat (10) @(negedge clk);
    pwm = 1'b0;
    repeat (1100) @(negedge clk);
    check("drain_low", exp_q.size(), 0);
    check("overrun_clear", int'(overrun), 0);

    // Periods shorter than the divide time: any reported value is still 50
    free_exp = 50;
    repeat (12) run(10, 5, -1);
    check("overrun_set", int'(overrun), 1);
    repeat (30) @(negedge clk);
    check("overrun_sticky", int'(overrun), 1);

    // This rise lands in MEASURE, so the divider is busy a few cycles later
    pwm = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    pwm = 1'b0;
    free_exp = -1;
    repeat (100) @(negedge clk);
    check("post_rst_overrun", int'(overrun), 0);
    check("post_rst_duty", int'(duty), 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_duty_meter.md
# pwm_duty_meter

Receive-side counterpart of the PWM generator: samples a single PWM line, measures period and high time between consecutive rising edges, computes the duty cycle in whole percent (0–100), and drives three 7-segment digits in the same format the generator's control path displays. Used on the board to close the loop on generated PWM and in benches as a self-checking monitor.

## Interface
- `CNT_W`, 16: width of period/high-time counters; max measurable period 2^CNT_W−1 cycles.
- `TIMEOUT`, 65535: cycles without a rising edge before the line is declared static; must be ≤ 2^CNT_W−1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pwm_in`  in  1  asynchronous PWM input.
- `duty`  out  7  last measured duty cycle, binary 0..100.
- `duty_valid`  out  1  one-cycle pulse when `duty` updates.
- `overrun`  out  1  sticky; set when a period completes while the divider is busy; cleared only by `rst`.
- `HEX0`  out  7  ones digit, active-low, {g,f,e,d,c,b,a}.
- `HEX1`  out  7  tens digit, active-low, blank when duty < 10.
- `HEX2`  out  7  hundreds digit, active-low, shows "1" only at 100, else blank.

## Operation
- `pwm_in` → 2-flop synchronizer → edge detector (rise/fall flags, one cycle each).
- States: IDLE, MEASURE, DIVIDE.
  - IDLE: counters held at 0; first rise → MEASURE, `per_cnt`=1, `hi_cnt`=1.
  - MEASURE: `per_cnt` increments every cycle; `hi_cnt` increments while synchronized input is 1. On rise: latch `per_cnt`/`hi_cnt` into divider, restart both counters at 1, go to DIVIDE.
  - DIVIDE: restoring divider, numerator = hi×100 (CNT_W+7 bits), denominator = period; one quotient bit per cycle, CNT_W+7 cycles. Counters keep measuring the next period in parallel. On completion: register quotient into `duty`, pulse `duty_valid`, return to MEASURE.
- Rise during DIVIDE: sample discarded, counters still restart, `overrun` set.
- Quotient floored (see Configuration); result clamped to 100.
- Timeout: if `per_cnt` reaches `TIMEOUT` in MEASURE or DIVIDE (after divider completes), abort measurement, `duty` = 100 if synchronized input is 1 else 0, pulse `duty_valid`, go to IDLE.
- Display: hundreds/tens/ones derived combinationally from registered `duty`, then encoded; HEX outputs are registered (one cycle after `duty`).
- Encodings (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.

## Timing
- Reset values: `duty`=0, `duty_valid`=0, `overrun`=0, HEX0=1000000, HEX1=1111111, HEX2=1111111, state IDLE, counters 0.
- `rst` mid-operation: aborts divider and measurement, restores reset values next edge; first period after reset is never reported.
- Input-to-rise-flag latency: 3 cycles after `pwm_in` edge (2 sync + 1 detect).
- Rise flag → `duty_valid`: CNT_W+8 cycles (1 latch + CNT_W+7 divide); HEX update one cycle after `duty_valid`.
- Minimum period reported without overrun: CNT_W+8 cycles.
- Period of 1 cycle or glitch shorter than 1 cycle: not resolved; no requirement.

## Configuration
- `PWM_METER_ROUND_EN` defined: numerator becomes hi×100 + period/2 (floored), giving round-to-nearest; clamp to 100 still applies. Undefined: pure floor division.

## Test plan
- Reset with `pwm_in`=0 → HEX2=1111111, HEX1=1111111, HEX0=1000000, `duty`=0, no `duty_valid`.
- Period 100 cycles, high 50 (clk 10 ns) → `duty`=50 after second rise; HEX1=0010010, HEX0=1000000, HEX2 blank; one `duty_valid` per period thereafter.
- Step generator 50→60→70→60 (period 100) → `duty` tracks 60, 70, 60 within two periods of each change; HEX1 = 0000010, 1111000, 0000010.
- Period 300, high 100 → `duty`=33 (both configs); period 300, high 2 → 0 floor, 1 with `PWM_METER_ROUND_EN`.
- Hold `pwm_in`=1 for > `TIMEOUT` cycles (TIMEOUT=1000 in bench) → `duty`=100, HEX2=1111001, HEX1=1000000, HEX0=1000000; hold 0 → `duty`=0.
- Period 10 cycles with CNT_W=16 → `overrun`=1 and stays set; assert `rst` mid-divide → all outputs at reset values next cycle, `overrun`=0.
